calendar_clock_core: RTL and testbench

//   Parametrised next-generation timekeeping core: sec/min/hour/day/month/year in binary,

---
 rtl/calendar_clock_core.sv | 264 ++++++++++++++++++++++++++
 tb/tb_calendar_clock_core.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_clock_core.sv
// Binary calendar/clock core: prescaled second tick, carry chain through year,
// validated per-field writes with day clamping, 12/24 h view and alarm channels.
module calendar_clock_core #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 1,
    parameter int FAST_HZ   = 10_000,
    parameter int N_ALARMS  = 2,
    parameter int YEAR_BASE = 2000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                sel_fast,
    input  logic                wr_en,
    input  logic [2:0]          wr_field,
    input  logic [13:0]         wr_data,
    output logic                wr_err,
    input  logic                alm_wr,
    input  logic [2:0]          alm_idx,
    input  logic [4:0]          alm_hour,
    input  logic [5:0]          alm_min,
    input  logic                alm_on,
    input  logic [N_ALARMS-1:0] alm_ack,
    output logic [N_ALARMS-1:0] alm_hit,
    output logic [N_ALARMS-1:0] alm_flag,
    output logic                tick,
    output logic [5:0]          sec,
    output logic [5:0]          min,
    output logic [4:0]          hour,
    output logic [3:0]          hour12,
    output logic                pm,
    output logic [4:0]          day,
    output logic [3:0]          month,
    output logic [13:0]         year,
    output logic                leap
);

    localparam int DIV_SLOW = CLK_HZ / TICK_HZ;
    localparam int DIV_FAST = CLK_HZ / FAST_HZ;
    localparam int DIV_MAX  = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int PW       = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam logic [PW-1:0] LIM_SLOW = PW'(DIV_SLOW - 1);
    localparam logic [PW-1:0] LIM_FAST = PW'(DIV_FAST - 1);
    localparam logic [13:0]   YEAR_RST = 14'(YEAR_BASE);

    function automatic logic is_leap(input logic [13:0] y);
        return ((y % 14'd4 == 14'd0) && (y % 14'd100 != 14'd0)) || (y % 14'd400 == 14'd0);
    endfunction

    function automatic logic [4:0] days_in(input logic [3:0] m, input logic [13:0] y);
        case (m)
            4'd2:                         return is_leap(y) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:      return 5'd30;
            default:                      return 5'd31;
        endcase
    endfunction

    function automatic logic [3:0] to_hour12(input logic [4:0] h);
        if (h == 5'd0) begin
            return 4'd12;
        end else if (h > 5'd12) begin
            return 4'(h - 5'd12);
        end else begin
            return 4'(h);
        end
    endfunction

    logic [PW-1:0] pre_r;
    logic          tick_ce_r;
    logic          pend_r;
    logic          sel_r;
    logic [4:0]    a_hour_r [N_ALARMS];
    logic [5:0]    a_min_r  [N_ALARMS];
    logic [N_ALARMS-1:0] a_on_r;

    logic [5:0]    sec_s, min_s;
    logic [4:0]    hour_s, day_s, dim_cur_s, dim_new_s;
    logic [3:0]    month_s;
    logic [13:0]   year_s;
    logic          wr_err_s, tick_s, pend_s, clr_pre_s, do_tick_s;
    logic [PW-1:0] lim_s;
    logic [N_ALARMS-1:0] hit_s;

    // Next-state: a write always wins the cycle; a coincident tick is parked in pend_r.
    always_comb begin
        sec_s     = sec;
        min_s     = min;
        hour_s    = hour;
        day_s     = day;
        month_s   = month;
        year_s    = year;
        wr_err_s  = 1'b0;
        tick_s    = 1'b0;
        hit_s     = '0;
        pend_s    = pend_r;
        clr_pre_s = 1'b0;
        lim_s     = sel_fast ? LIM_FAST : LIM_SLOW;
        dim_cur_s = days_in(month, year);
        dim_new_s = dim_cur_s;
        do_tick_s = tick_ce_r | pend_r;
        if (wr_en) begin
            pend_s = do_tick_s;
            case (wr_field)
                3'd0: begin
                    if (wr_data <= 14'd59) begin
                        sec_s     = wr_data[5:0];
                        clr_pre_s = 1'b1;
                    end else begin
                        wr_err_s = 1'b1;
                    end
                end
                3'd1: begin
                    if (wr_data <= 14'd59) min_s = wr_data[5:0];
                    else wr_err_s = 1'b1;
                end
                3'd2: begin
                    if (wr_data <= 14'd23) hour_s = wr_data[4:0];
                    else wr_err_s = 1'b1;
                end
                3'd3: begin
                    if (wr_data >= 14'd1 && wr_data <= {9'd0, dim_cur_s}) day_s = wr_data[4:0];
                    else wr_err_s = 1'b1;
                end
                3'd4: begin
                    if (wr_data >= 14'd1 && wr_data <= 14'd12) begin
                        month_s   = wr_data[3:0];
                        dim_new_s = days_in(wr_data[3:0], year);
                        day_s     = (day > dim_new_s) ? dim_new_s : day;
                    end else begin
                        wr_err_s = 1'b1;
                    end
                end
                3'd5: begin
                    if (wr_data <= 14'd9999) begin
                        year_s    = wr_data;
                        dim_new_s = days_in(month, wr_data);
                        day_s     = (day > dim_new_s) ? dim_new_s : day;
                    end else begin
                        wr_err_s = 1'b1;
                    end
                end
                default: wr_err_s = 1'b1;
            endcase
        end else if (do_tick_s) begin
            pend_s = 1'b0;
            tick_s = 1'b1;
            if (sec != 6'd59) begin
                sec_s = sec + 6'd1;
            end else begin
                sec_s = 6'd0;
                if (min != 6'd59) begin
                    min_s = min + 6'd1;
                end else begin
                    min_s = 6'd0;
                    if (hour != 5'd23) begin
                        hour_s = hour + 5'd1;
                    end else begin
                        hour_s = 5'd0;
                        if (day < dim_cur_s) begin
                            day_s = day + 5'd1;
                        end else begin
                            day_s = 5'd1;
                            if (month != 4'd12) begin
                                month_s = month + 4'd1;
                            end else begin
                                month_s = 4'd1;
                                year_s  = (year == 14'd9999) ? 14'd0 : year + 14'd1;
                            end
                        end
                    end
                end
            end
            for (int k = 0; k < N_ALARMS; k++) begin
                hit_s[k] = a_on_r[k] && (sec_s == 6'd0) && (hour_s == a_hour_r[k])
                           && (min_s == a_min_r[k]);
            end
        end else begin
            pend_s = pend_r;
        end
    end

    // Prescaler: cleared on a rate change or a second write, strobes tick_ce on wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r     <= '0;
            tick_ce_r <= 1'b0;
            sel_r     <= sel_fast;
        end else begin
            sel_r     <= sel_fast;
            tick_ce_r <= 1'b0;
            if (sel_fast != sel_r || clr_pre_s) begin
                pre_r <= '0;
            end else if (run) begin
                if (pre_r >= lim_s) begin
                    pre_r     <= '0;
                    tick_ce_r <= 1'b1;
                end else begin
                    pre_r <= pre_r + PW'(1);
                end
            end else begin
                pre_r <= pre_r;
            end
        end
    end

    // Time/date registers and derived views, all registered from next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec      <= 6'd0;
            min      <= 6'd0;
            hour     <= 5'd0;
            day      <= 5'd1;
            month    <= 4'd1;
            year     <= YEAR_RST;
            hour12   <= 4'd12;
            pm       <= 1'b0;
            leap     <= is_leap(YEAR_RST);
            tick     <= 1'b0;
            wr_err   <= 1'b0;
            alm_hit  <= '0;
            alm_flag <= '0;
            pend_r   <= 1'b0;
        end else begin
            sec      <= sec_s;
            min      <= min_s;
            hour     <= hour_s;
            day      <= day_s;
            month    <= month_s;
            year     <= year_s;
            hour12   <= to_hour12(hour_s);
            pm       <= (hour_s >= 5'd12);
            leap     <= is_leap(year_s);
            tick     <= tick_s;
            wr_err   <= wr_err_s;
            alm_hit  <= hit_s;
            alm_flag <= (alm_flag & ~alm_ack) | hit_s;
            pend_r   <= pend_s;
        end
    end

    // Alarm channel registers; indices beyond the channel count match no k.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_on_r <= '0;
            for (int k = 0; k < N_ALARMS; k++) begin
                a_hour_r[k] <= 5'd0;
                a_min_r[k]  <= 6'd0;
            end
        end else begin
            for (int k = 0; k < N_ALARMS; k++) begin
                if (alm_wr && alm_idx == 3'(k)) begin
                    a_hour_r[k] <= alm_hour;
                    a_min_r[k]  <= alm_min;
                    a_on_r[k]   <= alm_on;
                end else begin
                    a_hour_r[k] <= a_hour_r[k];
                    a_min_r[k]  <= a_min_r[k];
                    a_on_r[k]   <= a_on_r[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_calendar_clock_core.sv
// Bench for calendar_clock_core: write-validation table, hand-written carry/alarm/
// reset sequences and randomized dates checked against a seconds-of-day model.
module tb_calendar_clock_core;
    localparam int NA = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, run, sel_fast, wr_en, wr_err, alm_wr, alm_on, tick, pm, leap;
    logic [2:0]  wr_field, alm_idx;
    logic [13:0] wr_data, year;
    logic [4:0]  alm_hour, hour, day;
    logic [5:0]  alm_min, sec, min;
    logic [3:0]  hour12, month;
    logic [NA-1:0] alm_ack, alm_hit, alm_flag;

    calendar_clock_core #(.CLK_HZ(40), .TICK_HZ(4), .FAST_HZ(20), .N_ALARMS(NA), .YEAR_BASE(2000)) dut (
        .clk(clk), .rst(rst), .run(run), .sel_fast(sel_fast), .wr_en(wr_en),
        .wr_field(wr_field), .wr_data(wr_data), .wr_err(wr_err), .alm_wr(alm_wr),
        .alm_idx(alm_idx), .alm_hour(alm_hour), .alm_min(alm_min), .alm_on(alm_on),
        .alm_ack(alm_ack), .alm_hit(alm_hit), .alm_flag(alm_flag), .tick(tick),
        .sec(sec), .min(min), .hour(hour), .hour12(hour12), .pm(pm), .day(day),
        .month(month), .year(year), .leap(leap)
    );

    int checks = 0;
    int errors = 0;
    int my, mmo, md, mh, mmi, ms;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_leap(input int y);
        return (y % 400 == 0) || ((y % 4 == 0) && (y % 100 != 0));
    endfunction

    function automatic int m_dim(input int m, input int y);
        int t[12];
        t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        return t[m-1] + ((m == 2 && m_leap(y)) ? 1 : 0);
    endfunction

    function automatic logic [63:0] pack(input int y, input int mo, input int d,
                                         input int h, input int mi, input int s);
        int h12;
        h12 = (h % 12 == 0) ? 12 : h % 12;
        return {18'd0, 14'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s), 4'(h12), (h >= 12), m_leap(y)};
    endfunction

    function automatic logic [63:0] snap();
        return {18'd0, year, month, day, hour, min, sec, hour12, pm, leap};
    endfunction

    task automatic m_tick();
        int t;
        t = mh * 3600 + mmi * 60 + ms + 1;
        if (t == 86400) begin
            t = 0;
            md++;
            if (md > m_dim(mmo, my)) begin
                md = 1;
                mmo++;
                if (mmo > 12) begin
                    mmo = 1;
                    my  = (my + 1) % 10000;
                end
            end
        end
        mh = t / 3600; mmi = (t / 60) % 60; ms = t % 60;
    endtask

    task automatic m_write(input int f, input int v, output bit err);
        err = 1'b0;
        case (f)
            0: if (v < 60) ms = v; else err = 1'b1;
            1: if (v < 60) mmi = v; else err = 1'b1;
            2: if (v < 24) mh = v; else err = 1'b1;
            3: if (v >= 1 && v <= m_dim(mmo, my)) md = v; else err = 1'b1;
            4: if (v >= 1 && v <= 12) begin mmo = v; if (md > m_dim(mmo, my)) md = m_dim(mmo, my); end
               else err = 1'b1;
            5: if (v <= 9999) begin my = v; if (md > m_dim(mmo, my)) md = m_dim(mmo, my); end
               else err = 1'b1;
            default: err = 1'b1;
        endcase
    endtask

    task automatic wr(input int f, input int d);
        wr_en = 1'b1; wr_field = 3'(f); wr_data = 14'(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic set_time(input int y, input int mo, input int d, input int h, input int mi, input int s);
        run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wr(3, 1); wr(5, y); wr(4, mo); wr(3, d); wr(2, h); wr(1, mi); wr(0, s);
        my = y; mmo = mo; md = d; mh = h; mmi = mi; ms = s;
    endtask

    task automatic wait_tick(output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (tick) begin ok = 1'b1; break; end
        end
        chk("tick_seen", 64'(ok), 64'd1);
    endtask

    task automatic run_ticks(input int n);
        bit ok; int cyc;
        run = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_tick(ok, cyc);
            m_tick();
        end
        run = 1'b0;
    endtask

    typedef struct {
        int f; int d; logic err; int dd; int mo; int yr; int hr;
    } vec_t;
    vec_t tbl [22];

    initial begin
        bit ok, merr;
        int cyc, n, f, v, y, mo, d, h, mi, s;
        rst = 1'b1; run = 1'b0; sel_fast = 1'b1; wr_en = 1'b0; wr_field = 3'd0; wr_data = 14'd0;
        alm_wr = 1'b0; alm_idx = 3'd0; alm_hour = 5'd0; alm_min = 6'd0; alm_on = 1'b0; alm_ack = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_time", snap(), pack(2000, 1, 1, 0, 0, 0));
        chk("reset_flags", 64'({tick, wr_err, alm_hit, alm_flag}), 64'd0);
        rst = 1'b0;

        tbl[0]  = '{5, 2023, 1'b0, 1, 1, 2023, 0};
        tbl[1]  = '{3, 31,   1'b0, 31, 1, 2023, 0};
        tbl[2]  = '{4, 2,    1'b0, 28, 2, 2023, 0};
        tbl[3]  = '{5, 2024, 1'b0, 28, 2, 2024, 0};
        tbl[4]  = '{3, 29,   1'b0, 29, 2, 2024, 0};
        tbl[5]  = '{5, 2023, 1'b0, 28, 2, 2023, 0};
        tbl[6]  = '{4, 3,    1'b0, 28, 3, 2023, 0};
        tbl[7]  = '{3, 31,   1'b0, 31, 3, 2023, 0};
        tbl[8]  = '{4, 4,    1'b0, 30, 4, 2023, 0};
        tbl[9]  = '{3, 31,   1'b1, 30, 4, 2023, 0};
        tbl[10] = '{3, 0,    1'b1, 30, 4, 2023, 0};
        tbl[11] = '{4, 0,    1'b1, 30, 4, 2023, 0};
        tbl[12] = '{4, 13,   1'b1, 30, 4, 2023, 0};
        tbl[13] = '{5, 10000, 1'b1, 30, 4, 2023, 0};
        tbl[14] = '{6, 5,    1'b1, 30, 4, 2023, 0};
        tbl[15] = '{7, 5,    1'b1, 30, 4, 2023, 0};
        tbl[16] = '{0, 60,   1'b1, 30, 4, 2023, 0};
        tbl[17] = '{1, 60,   1'b1, 30, 4, 2023, 0};
        tbl[18] = '{2, 24,   1'b1, 30, 4, 2023, 0};
        tbl[19] = '{2, 23,   1'b0, 30, 4, 2023, 23};
        tbl[20] = '{5, 9999, 1'b0, 30, 4, 9999, 23};
        tbl[21] = '{4, 2,    1'b0, 28, 2, 9999, 23};
        for (int i = 0; i < 22; i++) begin
            wr(tbl[i].f, tbl[i].d);
            chk($sformatf("wr_vec%0d", i), 64'({wr_err, day, month, year, hour}),
                64'({tbl[i].err, 5'(tbl[i].dd), 4'(tbl[i].mo), 14'(tbl[i].yr), 5'(tbl[i].hr)}));
        end
        wr(6, 0);
        @(posedge clk); #1;
        chk("wr_err_pulse", 64'(wr_err), 64'd0);

        set_time(2023, 12, 31, 23, 59, 59);
        run_ticks(1);
        chk("new_year", snap(), pack(2024, 1, 1, 0, 0, 0));
        @(posedge clk); #1;
        chk("tick_one_cycle", 64'(tick), 64'd0);
        set_time(2024, 2, 28, 23, 59, 59);  run_ticks(1);
        chk("feb28_leap", snap(), pack(2024, 2, 29, 0, 0, 0));
        set_time(2024, 2, 29, 23, 59, 59);  run_ticks(1);
        chk("feb29_end", snap(), pack(2024, 3, 1, 0, 0, 0));
        set_time(2100, 2, 28, 23, 59, 59);  run_ticks(1);
        chk("feb28_2100", snap(), pack(2100, 3, 1, 0, 0, 0));
        set_time(9999, 12, 31, 23, 59, 59); run_ticks(1);
        chk("year_wrap", snap(), pack(0, 1, 1, 0, 0, 0));
        set_time(2023, 4, 30, 23, 59, 59);  run_ticks(1);
        chk("apr30_end", snap(), pack(2023, 5, 1, 0, 0, 0));

        run = 1'b1;
        wait_tick(ok, cyc);
        wait_tick(ok, cyc);
        chk("fast_period", 64'(cyc), 64'd2);
        run = 1'b0; sel_fast = 1'b0;
        @(posedge clk); #1;
        run = 1'b1;
        wait_tick(ok, cyc);
        wait_tick(ok, cyc);
        chk("slow_period", 64'(cyc), 64'd10);
        run = 1'b0; sel_fast = 1'b1;

        // Write landing on the same cycle as tick_ce: second applied one cycle later.
        set_time(2024, 6, 15, 7, 20, 0);
        wr(0, 10);
        run = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        wr(1, 5);
        chk("wr_vs_tick_write", 64'({min, sec, tick}), 64'({6'd5, 6'd10, 1'b0}));
        @(posedge clk); #1;
        chk("wr_vs_tick_pend", 64'({min, sec, tick}), 64'({6'd5, 6'd11, 1'b1}));
        n = 0;
        for (int i = 0; i < 200; i++) begin
            wr_en = (i % 5 == 0) && (i < 190); wr_field = 3'd1; wr_data = 14'd5;
            @(posedge clk); #1;
            if (tick) n++;
        end
        wr_en = 1'b0; run = 1'b0;
        chk("no_tick_lost", 64'(n), 64'd100);
        chk("sec_after_100", 64'(sec), 64'd51);

        alm_wr = 1'b1; alm_idx = 3'd0; alm_hour = 5'd7; alm_min = 6'd30; alm_on = 1'b1;
        @(posedge clk); #1;
        alm_idx = 3'd1; alm_min = 6'd31;
        @(posedge clk); #1;
        alm_wr = 1'b0;
        set_time(2024, 6, 15, 7, 29, 58);
        run = 1'b1;
        wait_tick(ok, cyc);
        chk("alm_tick1", 64'({alm_hit, alm_flag}), 64'd0);
        wait_tick(ok, cyc);
        run = 1'b0;
        chk("alm_tick2", 64'({alm_hit, alm_flag}), 64'({2'b01, 2'b01}));
        repeat (3) @(posedge clk);
        #1;
        chk("alm_sticky", 64'({alm_hit, alm_flag}), 64'({2'b00, 2'b01}));
        alm_ack = 2'b01;
        @(posedge clk); #1;
        alm_ack = 2'b00;
        chk("alm_ack", 64'(alm_flag), 64'd0);
        set_time(2024, 6, 15, 7, 30, 0);
        chk("alm_write_nohit", 64'({alm_hit, alm_flag}), 64'd0);
        set_time(2024, 6, 15, 7, 30, 59);
        alm_ack = 2'b10;
        run_ticks(1);
        chk("alm_set_beats_ack", 64'({alm_hit, alm_flag}), 64'({2'b10, 2'b10}));
        alm_ack = 2'b00;

        set_time(2024, 6, 15, 13, 0, 0);
        chk("hour13_view", 64'({hour12, pm}), 64'({4'd1, 1'b1}));
        wr(2, 12);
        chk("hour12_view", 64'({hour12, pm}), 64'({4'd12, 1'b1}));
        wr(2, 0);
        chk("hour0_view", 64'({hour12, pm}), 64'({4'd12, 1'b0}));
        wr(0, 10);
        run = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        wr(1, 7);
        rst = 1'b1; run = 1'b0;
        @(posedge clk); #1;
        chk("rst_pending_state", snap(), pack(2000, 1, 1, 0, 0, 0));
        chk("rst_pending_flags", 64'({tick, wr_err, alm_hit, alm_flag}), 64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pending_dropped", 64'({tick, sec}), 64'd0);

        for (int it = 0; it < 16; it++) begin
            case ($urandom % 5)
                0: y = int'($urandom % 10000);
                1: y = 9999;
                2: y = 2100;
                3: y = 2000 + 4 * int'($urandom % 10);
                default: y = 1900;
            endcase
            mo = 1 + int'($urandom % 12);
            d  = ($urandom % 2 == 0) ? m_dim(mo, y) : 1 + int'($urandom % 28);
            h  = ($urandom % 2 == 0) ? 23 : int'($urandom % 24);
            mi = ($urandom % 2 == 0) ? 59 : int'($urandom % 60);
            s  = 55 + int'($urandom % 5);
            set_time(y, mo, d, h, mi, s);
            chk($sformatf("rnd_set%0d", it), snap(), pack(my, mmo, md, mh, mmi, ms));
            run_ticks(1 + int'($urandom % 6));
            chk($sformatf("rnd_run%0d", it), snap(), pack(my, mmo, md, mh, mmi, ms));
            f = int'($urandom % 8);
            case (f)
                3: v = int'($urandom % 33);
                4: v = int'($urandom % 14);
                5: v = ($urandom % 2 == 0) ? 9990 + int'($urandom % 20) : int'($urandom % 10000);
                default: v = int'($urandom % 70);
            endcase
            m_write(f, v, merr);
            wr(f, v);
            chk($sformatf("rnd_wr%0d", it), {17'd0, wr_err, snap()[45:0]},
                {17'd0, merr, pack(my, mmo, md, mh, mmi, ms)[45:0]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
